// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline control for the 5-stage datapath. It handles three conditions:
//   - a load-use hazard that forwarding cannot cover,
//   - wrong-path instructions behind a taken branch that resolves in MEM,
//   - a multi-cycle data-memory access, during which the whole pipeline freezes.
// It drives the PC, IF/ID, ID/EX and EX/MEM write/flush controls. It also keeps
// saturating stall/flush performance counters and a sticky memory-timeout error.
//
// Ports
//   clock              rising-edge system clock
//   reset              asynchronous, active-low reset
//   if_id_rs/rt        source registers of the instruction in IF/ID
//   id_ex_rt           destination register of the instruction in ID/EX
//   id_ex_memRead      ID/EX instruction is a load
//   ex_mem_branchTaken taken branch/jump resolved in MEM
//   dmem_req           EX/MEM issues a data-memory access this cycle
//   dmem_ready         data memory completes the access this cycle
//   clear_counters     synchronous clear of stall_count / flush_count
//   pc_write           PC updates this cycle
//   if_id_write        IF/ID register loads
//   id_ex_bubble       zero ID/EX control fields (insert nop)
//   if_id_flush        clear IF/ID
//   id_ex_flush        clear ID/EX
//   ex_mem_flush       clear EX/MEM
//   freeze             every pipeline register and the PC hold
//   stall_count        cycles lost to a load-use stall or a freeze (saturating)
//   flush_count        taken-branch flush events (saturating)
//   timeout_err        sticky: a memory wait exceeded MAX_WAIT cycles
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_WAIT   = 16,
  parameter int WAIT_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           if_id_rs,
  input  logic [4:0]           if_id_rt,
  input  logic [4:0]           id_ex_rt,
  input  logic                 id_ex_memRead,
  input  logic                 ex_mem_branchTaken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  input  logic                 clear_counters,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 id_ex_bubble,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 freeze,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MAX_WAIT);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

  state_t                state;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic                  load_use;
  logic                  mem_stall;
  logic                  branch_flush;
  logic                  load_use_stall;

  // A load whose destination feeds the next instruction; r0 never creates a hazard.
  assign load_use = id_ex_memRead && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

  // Memory stall dominates everything; the unencoded state value is treated as ERROR.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    mem_stall = 1'b1;
    case (state)
      RUN:      mem_stall = dmem_req && !dmem_ready;
      MEM_WAIT: mem_stall = !dmem_ready;
      default:  mem_stall = 1'b1;
    endcase
  end

  // A taken branch flushes the load-use instruction too, so the stall is dropped.
  assign branch_flush   = !mem_stall && ex_mem_branchTaken;
  assign load_use_stall = !mem_stall && !ex_mem_branchTaken && load_use;

  // Control outputs act in the same cycle. While reset is held, the pipeline is frozen.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    freeze       = 1'b0;
    if (!reset || mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      freeze      = 1'b1;
    end else if (branch_flush) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Memory-wait state machine. wait_cnt counts the MEM_WAIT cycles of the current access.
  // NOTE: the asynchronous reset returns the block to RUN immediately, even mid-access, without waiting for a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      case (state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_WIDTH'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state       <= ERROR;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
          end
        end
        default: begin
          state <= ERROR;
        end
      endcase
    end
  end

  // Performance counters saturate at all-ones. A clear takes precedence over a same-edge increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (clear_counters) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if ((mem_stall || load_use_stall) && (stall_count != CNT_MAX))
        stall_count <= stall_count + CNT_WIDTH'(1);
      if (branch_flush && (flush_count != CNT_MAX))
        flush_count <= flush_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Self-checking bench for hazard_stall_unit. It runs two instances: default
// parameters, and a 4-bit counter variant. Both see the same stimulus.
//
// A behavioural model tracks the following:
//   - whether a memory access is outstanding,
//   - how many consecutive freeze cycles that access has cost,
//   - whether the unit has timed out,
//   - the counter values, each with its own saturation limit.
// A compare process checks every DUT output against the model on each falling
// edge. Directed scenarios with literal expectations run first. Randomized
// traffic follows.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

  localparam int MAX_WAIT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
  logic        id_ex_memRead, ex_mem_branchTaken;
  logic        dmem_req, dmem_ready, clear_counters;

  logic        pc_write, if_id_write, id_ex_bubble;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, freeze;
  logic [15:0] stall_count, flush_count;
  logic        timeout_err;

  logic        n_pc_write, n_if_id_write, n_id_ex_bubble;
  logic        n_if_id_flush, n_id_ex_flush, n_ex_mem_flush, n_freeze;
  logic [3:0]  n_stall_count, n_flush_count;
  logic        n_timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  hazard_stall_unit dut (
    .clock(clock), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_ex_rt(id_ex_rt),
    .id_ex_memRead(id_ex_memRead), .ex_mem_branchTaken(ex_mem_branchTaken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .clear_counters(clear_counters),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .freeze(freeze), .stall_count(stall_count), .flush_count(flush_count),
    .timeout_err(timeout_err)
  );

  hazard_stall_unit #(.CNT_WIDTH(4)) dut_narrow (
    .clock(clock), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_ex_rt(id_ex_rt),
    .id_ex_memRead(id_ex_memRead), .ex_mem_branchTaken(ex_mem_branchTaken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .clear_counters(clear_counters),
    .pc_write(n_pc_write), .if_id_write(n_if_id_write), .id_ex_bubble(n_id_ex_bubble),
    .if_id_flush(n_if_id_flush), .id_ex_flush(n_id_ex_flush), .ex_mem_flush(n_ex_mem_flush),
    .freeze(n_freeze), .stall_count(n_stall_count), .flush_count(n_flush_count),
    .timeout_err(n_timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_pending;   // an access is outstanding
  int m_frozen;    // freeze cycles spent on the current access
  bit m_dead;      // timed out; frozen until reset
  bit m_timeout;
  int m_stall, m_flush, m_stall4, m_flush4;

  function automatic bit m_busy();
    return m_dead || ((m_pending || dmem_req) && !dmem_ready);
  endfunction

  function automatic bit m_load_use();
    return id_ex_memRead && id_ex_rt != 0 && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
  endfunction

  function automatic int sat_inc(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pending = 0; m_frozen = 0; m_dead = 0; m_timeout = 0;
      m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    end else begin
      if (clear_counters) begin
        m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
      end else if (m_busy() || (!ex_mem_branchTaken && m_load_use())) begin
        m_stall = sat_inc(m_stall, 65535); m_stall4 = sat_inc(m_stall4, 15);
      end else if (ex_mem_branchTaken) begin
        m_flush = sat_inc(m_flush, 65535); m_flush4 = sat_inc(m_flush4, 15);
      end
      if (!m_dead) begin
        if ((m_pending || dmem_req) && !dmem_ready) begin
          m_pending = 1;
          m_frozen++;
          if (m_frozen == MAX_WAIT + 1) begin
            m_dead = 1; m_timeout = 1;
          end
        end else if (m_pending) begin
          m_pending = 0; m_frozen = 0;
        end
      end
    end
  end

  // Compare process: every output of both instances, every falling edge.
  // Expected control vector order: pc_write, if_id_write, bubble, three flushes, freeze.
  always @(negedge clock) begin
    logic [6:0] e;
    if (!reset || m_busy())                 e = 7'b0000001;
    else if (ex_mem_branchTaken)            e = 7'b1101110;
    else if (m_load_use())                  e = 7'b0010000;
    else                                    e = 7'b1100000;
    check("ctrl", 32'({pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
                       ex_mem_flush, freeze}), 32'(e));
    check("ctrl_narrow", 32'({n_pc_write, n_if_id_write, n_id_ex_bubble, n_if_id_flush,
                              n_id_ex_flush, n_ex_mem_flush, n_freeze}), 32'(e));
    check("stall_count", 32'(stall_count), 32'(m_stall));
    check("flush_count", 32'(flush_count), 32'(m_flush));
    check("timeout_err", 32'(timeout_err), 32'(m_timeout));
    check("stall_count_narrow", 32'(n_stall_count), 32'(m_stall4));
    check("flush_count_narrow", 32'(n_flush_count), 32'(m_flush4));
    check("timeout_err_narrow", 32'(n_timeout_err), 32'(m_timeout));
  end

  // Advance to just after the next rising edge.
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    if_id_rs = 0; if_id_rt = 0; id_ex_rt = 0; id_ex_memRead = 0;
    ex_mem_branchTaken = 0; dmem_req = 0; dmem_ready = 0; clear_counters = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();

    // Reset state
    @(negedge clock);
    check("rst_freeze", 32'(freeze), 1);
    check("rst_pc_write", 32'(pc_write), 0);
    check("rst_if_id_write", 32'(if_id_write), 0);
    check("rst_stall_count", 32'(stall_count), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    next();
    reset = 1'b1;

    // Load-use: one stall cycle
    id_ex_memRead = 1; id_ex_rt = 8; if_id_rs = 8;
    @(negedge clock);
    check("lu_pc_write", 32'(pc_write), 0);
    check("lu_if_id_write", 32'(if_id_write), 0);
    check("lu_bubble", 32'(id_ex_bubble), 1);
    next();
    id_ex_memRead = 0;
    check("lu_stall_count", 32'(stall_count), 1);
    @(negedge clock);
    check("lu_released", 32'(pc_write), 1);

    // r0 destination never stalls; clear counters on the same cycle
    next();
    id_ex_memRead = 1; id_ex_rt = 0; if_id_rs = 0; clear_counters = 1;
    @(negedge clock);
    check("r0_pc_write", 32'(pc_write), 1);
    check("r0_bubble", 32'(id_ex_bubble), 0);
    next();
    clear_counters = 0; ex_mem_branchTaken = 1;
    @(negedge clock);
    check("br_flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'h7);
    check("br_pc_write", 32'(pc_write), 1);
    next();
    // A branch coincident with a real load-use discards the stall
    id_ex_rt = 8; if_id_rs = 8;
    check("br_flush_count", 32'(flush_count), 1);
    check("br_stall_count", 32'(stall_count), 0);
    @(negedge clock);
    check("br_lu_bubble", 32'(id_ex_bubble), 0);
    check("br_lu_pc_write", 32'(pc_write), 1);
    next();
    idle_inputs();
    check("br_lu_flush_count", 32'(flush_count), 2);
    check("br_lu_stall_count", 32'(stall_count), 0);

    // Three-cycle memory wait
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("mw_freeze", 32'(freeze), 1);
      check("mw_pc_write", 32'(pc_write), 0);
      next();
    end
    dmem_ready = 1;
    @(negedge clock);
    check("mw_done_freeze", 32'(freeze), 0);
    check("mw_done_pc_write", 32'(pc_write), 1);
    next();
    dmem_req = 0; dmem_ready = 0;
    check("mw_stall_count", 32'(stall_count), 3);
    @(negedge clock);
    check("mw_back_in_run", 32'(freeze), 0);

    // Timeout after MAX_WAIT+1 freeze cycles
    next();
    clear_counters = 1;
    next();
    clear_counters = 0; dmem_req = 1;
    for (int i = 1; i <= MAX_WAIT + 1; i++) begin
      @(negedge clock);
      check("to_freeze", 32'(freeze), 1);
      next();
      check("to_timeout_err", 32'(timeout_err), (i == MAX_WAIT + 1) ? 1 : 0);
    end
    dmem_req = 0; dmem_ready = 1;
    @(negedge clock);
    check("err_freeze_held", 32'(freeze), 1);
    next();
    check("err_stall_count", 32'(stall_count), MAX_WAIT + 2);

    // Reset clears ERROR asynchronously
    reset = 0;
    #1;
    check("err_rst_timeout", 32'(timeout_err), 0);
    check("err_rst_stall_count", 32'(stall_count), 0);
    next();
    reset = 1; dmem_req = 1; dmem_ready = 0;
    next();
    next();
    // Now mid-MEM_WAIT
    reset = 0;
    #2;
    check("mw_rst_freeze", 32'(freeze), 1);
    check("mw_rst_pc_write", 32'(pc_write), 0);
    check("mw_rst_stall_count", 32'(stall_count), 0);
    next();
    reset = 1; dmem_req = 0;
    @(negedge clock);
    check("mw_rst_run", 32'(freeze), 0);
    check("mw_rst_timeout", 32'(timeout_err), 0);

    // Saturation of the narrow counter, then clear during a stall
    next();
    id_ex_memRead = 1; id_ex_rt = 8; if_id_rs = 8;
    repeat (20) next();
    check("sat_stall_count", 32'(stall_count), 20);
    check("sat_stall_count_narrow", 32'(n_stall_count), 15);
    clear_counters = 1;
    next();
    check("clr_stall_count", 32'(stall_count), 0);
    check("clr_stall_count_narrow", 32'(n_stall_count), 0);
    idle_inputs();

    // Randomized traffic. Odd phases make dmem_ready rare so timeouts occur.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      int ready_pct;
      next();
      ready_pct = ((cyc / 700) % 2 == 1) ? 4 : 60;
      reset              = ($urandom_range(0, 249) != 0);
      if_id_rs           = 5'($urandom_range(0, 3));
      if_id_rt           = 5'($urandom_range(0, 3));
      id_ex_rt           = 5'($urandom_range(0, 3));
      id_ex_memRead      = ($urandom_range(0, 99) < 50);
      ex_mem_branchTaken = ($urandom_range(0, 99) < 20);
      dmem_req           = ($urandom_range(0, 99) < 30);
      dmem_ready         = ($urandom_range(0, 99) < ready_pct);
      clear_counters     = ($urandom_range(0, 99) < 2);
    end
    next();
    reset = 1;
    idle_inputs();
    @(negedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
